// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel emits a tick every D
// enabled cycles and a divided clock, with glitch-free ratio updates at period boundaries.

module clock_divider_ch #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             en,
    input  logic             upd,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             tick,
    output logic             clkd,
    output logic             pend
);
    localparam logic [CNT_W-1:0] DEF = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt, div_act, div_nxt, d_cur;
    logic             en_q, rise, wrap, direct;

    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] d);
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    // On an enable rise the incoming ratio must already govern the first period.
    always_comb begin
        rise   = en & ~en_q;
        d_cur  = (rise && upd) ? eff(cfg_div) : eff(div_act);
        wrap   = en && (cnt == d_cur - CNT_W'(1));
        direct = upd && (!en || rise || wrap);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_act <= DEF;
            div_nxt <= DEF;
            pend    <= 1'b0;
            tick    <= 1'b0;
            clkd    <= 1'b0;
            en_q    <= 1'b0;
        end else if (run) begin
            en_q <= en;
            if (direct)
                div_act <= cfg_div;
            else if (pend && (!en || wrap))
                div_act <= div_nxt;

            if (!en || wrap)
                pend <= 1'b0;
            else if (upd && !rise) begin
                div_nxt <= cfg_div;
                pend    <= 1'b1;
            end

            if (!en) begin
                cnt  <= '0;
                tick <= 1'b0;
                clkd <= 1'b0;
            end else if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
                clkd <= ~clkd;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end
endmodule

module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] clk_div_o,
    output logic [NUM_CH-1:0] pending_o
);
    logic              run_q;
    logic [NUM_CH-1:0] upd;

    // Reset deasserts on a clock edge; channels start counting on the edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

    // Out-of-range channel numbers match nothing, so they are accepted and dropped.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int k = 0; k < NUM_CH; k++)
            if (cfg_ch_i == CH_W'(k))
                cfg_ready_o = !pending_o[k];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign upd[g] = cfg_valid_i && cfg_ready_o && (cfg_ch_i == CH_W'(g));

        clock_divider_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (run_q),
            .en      (en_i[g]),
            .upd     (upd[g]),
            .cfg_div (cfg_div_i),
            .tick    (tick_o[g]),
            .clkd    (clk_div_o[g]),
            .pend    (pending_o[g])
        );
    end
endmodule
